// File: rtl/symbol_packer_if.sv
// Downstream word handshake for symbol_packer.
// master drives out/out_count/out_valid; slave drives out_ready.
interface symbol_packer_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 4
);
  logic [WORD_W-1:0] out;
  logic [CNT_W-1:0]  out_count;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out,
    output out_count,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out,
    input  out_count,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/symbol_packer.sv
// Packs 4-bit symbols little-nibble-first into words, FWFT FIFO out.
// Ports: clk, rst(async low), in/in_valid/flush, bus, overflow, fifo_level.
module symbol_packer #(
  parameter int SYM_W      = 4,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int SPW = WORD_W / SYM_W,
  localparam int CW  = $clog2(SPW) + 1,
  localparam int AW  = $clog2(FIFO_DEPTH),
  localparam int LW  = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SYM_W-1:0]   in,
  input  logic               in_valid,
  input  logic               flush,
  symbol_packer_if.master    bus,
  output logic               overflow,
  output logic [LW-1:0]      fifo_level
);

  logic [WORD_W-1:0] pack;
  logic [WORD_W-1:0] pack_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;

  logic [WORD_W-1:0] mem_w [FIFO_DEPTH];
  logic [CW-1:0]     mem_c [FIFO_DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [LW-1:0]     level;
  logic              ovf;

  logic push;
  logic pop;
  logic full;
  logic wr;
  logic drop;

  // The incoming symbol lands before the push decision, so a
  // flush alongside a symbol pushes count+1.
  always_comb begin
    pack_nxt = pack;
    cnt_nxt  = cnt;
    if (in_valid) begin
      for (int k = 0; k < SPW; k++) begin
        if (cnt == CW'(k))
          pack_nxt[k*SYM_W +: SYM_W] = in;
      end
      cnt_nxt = cnt + CW'(1);
    end
  end

  assign push = (cnt_nxt == CW'(SPW)) ||
                (flush && (cnt_nxt != '0));
  assign full = (level == LW'(FIFO_DEPTH));
  assign pop  = bus.out_valid && bus.out_ready;
  // When full, a same-edge pop frees the slot at wp (== rp).
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;

  assign bus.out_valid = (level != '0);
  assign bus.out       = bus.out_valid ? mem_w[rp] : '0;
  assign bus.out_count = bus.out_valid ? mem_c[rp] : '0;
  assign overflow      = ovf;
  assign fifo_level    = level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack <= '0;
      cnt  <= '0;
    end else if (push) begin
      pack <= '0;
      cnt  <= '0;
    end else begin
      pack <= pack_nxt;
      cnt  <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_w[i] <= '0;
        mem_c[i] <= '0;
      end
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr) begin
        mem_w[wp] <= pack_nxt;
        mem_c[wp] <= cnt_nxt;
        wp        <= wp + AW'(1);
      end
      if (pop)
        rp <= rp + AW'(1);
      level <= level + LW'(wr) - LW'(pop);
      if (drop)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_symbol_packer.sv
// Directed self-checking bench for symbol_packer.
// One task per scenario, inline comparisons.
module tb_symbol_packer;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic       in_valid;
  logic       flush;
  logic       overflow;
  logic [2:0] fifo_level;

  int tests;
  int fails;

  symbol_packer_if #(.WORD_W(32), .CNT_W(4)) bus ();

  symbol_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .in_valid   (in_valid),
    .flush      (flush),
    .bus        (bus),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [3:0] s,
                      input logic f);
    in_valid = v;
    in       = s;
    flush    = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    in       = 4'h0;
  endtask

  task automatic test_reset;
    tests++;
    if (bus.out !== 32'h0) begin
      fails++;
      $display("FAIL reset_out: got %h want 0", bus.out);
    end
    tests++;
    if ({bus.out_valid, bus.out_count} !== 5'h0) begin
      fails++;
      $display("FAIL reset_vc: got %b want 0",
               {bus.out_valid, bus.out_count});
    end
    tests++;
    if ({overflow, fifo_level} !== 4'h0) begin
      fails++;
      $display("FAIL reset_ol: got %b want 0",
               {overflow, fifo_level});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: valid %b want 0",
               bus.out_valid);
    end
  endtask

  task automatic test_pack_one;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++)
      step(1'b1, 4'(i), 1'b0);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out !== 32'h87654321 ||
        bus.out_count !== 4'd8 || fifo_level !== 3'd1) begin
      fails++;
      $display("FAIL pack_one: v%b %h c%0d l%0d want 1 87654321 8 1",
               bus.out_valid, bus.out, bus.out_count, fifo_level);
    end
    step(1'b0, 4'h0, 1'b0);
    tests++;
    if (bus.out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      fails++;
      $display("FAIL pack_one_pop: v%b l%0d want 0 0",
               bus.out_valid, fifo_level);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush_partial;
    step(1'b1, 4'hA, 1'b0);
    step(1'b1, 4'hB, 1'b0);
    step(1'b1, 4'hC, 1'b0);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_pre: valid %b want 0", bus.out_valid);
    end
    step(1'b0, 4'h0, 1'b1);
    tests++;
    if (bus.out !== 32'h00000CBA || bus.out_count !== 4'd3 ||
        fifo_level !== 3'd1) begin
      fails++;
      $display("FAIL flush_partial: %h c%0d l%0d want 00000cba 3 1",
               bus.out, bus.out_count, fifo_level);
    end
    step(1'b0, 4'h0, 1'b1);
    tests++;
    if (fifo_level !== 3'd1) begin
      fails++;
      $display("FAIL flush_empty: level %0d want 1", fifo_level);
    end
    bus.out_ready = 1'b1;
    step(1'b0, 4'h0, 1'b0);
    bus.out_ready = 1'b0;
    tests++;
    if (fifo_level !== 3'd0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_drain: l%0d v%b want 0 0",
               fifo_level, bus.out_valid);
    end
  endtask

  task automatic test_flush_sym;
    for (int i = 1; i <= 7; i++)
      step(1'b1, 4'(i), 1'b0);
    step(1'b1, 4'hF, 1'b1);
    tests++;
    if (bus.out !== 32'hF7654321 || bus.out_count !== 4'd8 ||
        fifo_level !== 3'd1) begin
      fails++;
      $display("FAIL flush_sym: %h c%0d l%0d want f7654321 8 1",
               bus.out, bus.out_count, fifo_level);
    end
    step(1'b0, 4'h0, 1'b0);
    tests++;
    if (fifo_level !== 3'd1) begin
      fails++;
      $display("FAIL flush_sym_single: level %0d want 1", fifo_level);
    end
    bus.out_ready = 1'b1;
    step(1'b0, 4'h0, 1'b0);
    bus.out_ready = 1'b0;
    tests++;
    if (fifo_level !== 3'd0) begin
      fails++;
      $display("FAIL flush_sym_drain: level %0d want 0", fifo_level);
    end
  endtask

  task automatic test_full_pop;
    logic [31:0] exp [4];
    exp[0] = 32'hFEDCBA98;
    exp[1] = 32'h76543210;
    exp[2] = 32'hFEDCBA98;
    exp[3] = 32'h87654321;
    for (int i = 0; i < 32; i++)
      step(1'b1, 4'(i % 16), 1'b0);
    tests++;
    if (fifo_level !== 3'd4 || bus.out !== 32'h76543210) begin
      fails++;
      $display("FAIL full_fill: l%0d %h want 4 76543210",
               fifo_level, bus.out);
    end
    for (int i = 1; i <= 7; i++)
      step(1'b1, 4'(i), 1'b0);
    bus.out_ready = 1'b1;
    step(1'b1, 4'h8, 1'b0);
    tests++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_pop: l%0d ovf%b want 4 0",
               fifo_level, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out !== exp[i]) begin
        fails++;
        $display("FAIL full_pop_order%0d: v%b %h want 1 %h",
                 i, bus.out_valid, bus.out, exp[i]);
      end
      step(1'b0, 4'h0, 1'b0);
    end
    bus.out_ready = 1'b0;
    tests++;
    if (fifo_level !== 3'd0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_pop_end: l%0d ovf%b want 0 0",
               fifo_level, overflow);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp [4];
    logic [31:0] held;
    exp[0] = 32'h76543210;
    exp[1] = 32'hFEDCBA98;
    exp[2] = 32'h76543210;
    exp[3] = 32'hFEDCBA98;
    for (int i = 0; i < 32; i++)
      step(1'b1, 4'(i % 16), 1'b0);
    tests++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL bp_four: l%0d ovf%b want 4 0",
               fifo_level, overflow);
    end
    held = bus.out;
    for (int i = 32; i < 40; i++)
      step(1'b1, 4'(i % 16), 1'b0);
    tests++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL bp_overflow: l%0d ovf%b want 4 1",
               fifo_level, overflow);
    end
    tests++;
    if (bus.out !== held || bus.out_count !== 4'd8) begin
      fails++;
      $display("FAIL bp_stable: %h c%0d want %h 8",
               bus.out, bus.out_count, held);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out !== exp[i]) begin
        fails++;
        $display("FAIL bp_drain%0d: v%b %h want 1 %h",
                 i, bus.out_valid, bus.out, exp[i]);
      end
      step(1'b0, 4'h0, 1'b0);
    end
    step(1'b0, 4'h0, 1'b0);
    tests++;
    if (bus.out_valid !== 1'b0 || fifo_level !== 3'd0 ||
        overflow !== 1'b1) begin
      fails++;
      $display("FAIL bp_empty: v%b l%0d ovf%b want 0 0 1",
               bus.out_valid, fifo_level, overflow);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 21; i++)
      step(1'b1, 4'(i % 16), 1'b0);
    tests++;
    if (fifo_level !== 3'd2) begin
      fails++;
      $display("FAIL ar_pre: level %0d want 2", fifo_level);
    end
    #3;
    rst = 1'b0;
    #1;
    tests++;
    if (bus.out !== 32'h0 || bus.out_valid !== 1'b0 ||
        bus.out_count !== 4'd0 || fifo_level !== 3'd0 ||
        overflow !== 1'b0) begin
      fails++;
      $display("FAIL ar_clear: %h v%b c%0d l%0d ovf%b want all 0",
               bus.out, bus.out_valid, bus.out_count,
               fifo_level, overflow);
    end
    #1;
    rst = 1'b1;
    step(1'b0, 4'h0, 1'b0);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL ar_release: valid %b want 0", bus.out_valid);
    end
    for (int i = 8; i < 16; i++)
      step(1'b1, 4'(i), 1'b0);
    tests++;
    if (bus.out !== 32'hFEDCBA98 || bus.out_count !== 4'd8 ||
        fifo_level !== 3'd1) begin
      fails++;
      $display("FAIL ar_new: %h c%0d l%0d want fedcba98 8 1",
               bus.out, bus.out_count, fifo_level);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b0;
    in            = 4'h0;
    in_valid      = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    test_reset;
    test_pack_one;
    test_flush_partial;
    test_flush_sym;
    test_full_pop;
    test_backpressure;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/symbol_packer.md
Name: symbol_packer

Overview:
- Consumes the 4-bit decoded symbol stream from the Huffman decoder stage (`out_decoded` / `out_decoded_valid`).
- Packs symbols little-nibble-first into 32-bit words and buffers them in a small FIFO.
- Presents the words to the downstream consumer over a valid/ready handshake.
- The upstream decoder has no backpressure, so the block absorbs bursts and flags data loss when full.

Parameters:
- SYM_W, 4, symbol width in bits.
- WORD_W, 32, output word width; must be a multiple of SYM_W. SPW = WORD_W/SYM_W = 8 symbols per word.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in  input  SYM_W  decoded symbol.
- in_valid  input  1  `in` carries a symbol this cycle.
- flush  input  1  emit any partially filled word.
- out  output  WORD_W  packed word at FIFO head.
- out_count  output  clog2(SPW)+1 (4)  number of valid symbols in `out`, 1..8.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts `out` when `out_valid` & `out_ready`.
- overflow  output  1  sticky: a word was dropped.
- fifo_level  output  clog2(FIFO_DEPTH)+1 (3)  occupied entries, 0..FIFO_DEPTH.

Behaviour:
- Reset (rst=0, async) clears all state:
  - pack register = 0, symbol count = 0, FIFO pointers = 0.
  - out = 0, out_count = 0, out_valid = 0, overflow = 0, fifo_level = 0.
- Reset mid-operation discards the partial word and all FIFO contents; no word is emitted on reset release.
- Packing: the k-th accepted symbol (k = 0..7) is placed at bits [4k+3:4k]. `in` is ignored when `in_valid` = 0.
- Push on full word:
  - Accepting the 8th symbol pushes {word, count = 8} into the FIFO at that same edge.
  - The pack register and count clear to 0 at that edge.
- Push on flush:
  - flush = 1 with count > 0 pushes the partial word, zero-padded in unused upper nibbles, with out_count = count.
  - If `in_valid` is also high, that symbol is packed first, then the word is pushed with count+1.
  - flush with count = 0 and `in_valid` = 0 is a no-op. No empty words are ever pushed.
  - flush with count = 7 plus `in_valid` yields a single count = 8 push.
- FIFO is first-word-fall-through:
  - Push at edge N → out_valid = 1 after edge N when previously empty, so latency from 8th symbol to out_valid is 1 cycle.
  - out / out_count are stable while out_valid & !out_ready.
- Pop when out_valid & out_ready; the head advances at the edge.
- fifo_level = pushes − pops, updated at each edge; pointers wrap modulo FIFO_DEPTH.
- Full condition:
  - A push with fifo_level = FIFO_DEPTH and no simultaneous pop drops the word; FIFO contents are unchanged.
  - On a drop, overflow is set at that edge and holds until reset. The pack register still clears.
  - A push with a simultaneous pop while full is legal: level stays FIFO_DEPTH, nothing is dropped.
- Empty condition: out_ready while out_valid = 0 has no effect; level never underflows.
- Simultaneous push & pop at any level: level unchanged, ordering preserved.
- No combinational path from out_ready to any output other than through registered state.

Test Plan:
- Pack one word: symbols 1,2,…,8 on consecutive cycles, out_ready = 1 → one cycle after the 8th, out_valid = 1, out = 0x87654321, out_count = 8; popped the next edge, level returns to 0.
- Flush partial: symbols A,B,C then flush alone → out = 0x00000CBA, out_count = 3. Flush again with nothing pending → no new word.
- Flush with symbol: symbols 1..7, then flush with in_valid and in = 0xF → a single word 0xF7654321 with count 8; no second word.
- Backpressure and full:
  - Hold out_ready = 0 and feed 40 symbols (5 words) → fifo_level = 4, overflow = 1 after the 5th word.
  - Then out_ready = 1 → exactly 4 words drain in order: 0x76543210, 0xFEDCBA98, 0x76543210, 0xFEDCBA98 for an input sequence of 0..F repeating.
- Full with simultaneous pop: level = 4, complete a word on the same cycle as a pop → level stays 4, overflow stays 0, new word appears last.
- Async reset mid-word: after 5 symbols and 2 queued words, assert rst = 0 between clock edges → all outputs 0 immediately. After release, 8 new symbols produce a word containing only new data.
